// File: rtl/reg_file_8x8.sv
// Eight-entry, 8-bit general register file with two read ports and one write port.
// Latency: reads are combinational; a write lands at the CLK rising edge.
// Backpressure: BUSYWAIT high drops the write. Nothing is queued, and the writer re-presents it.
//
// Ports:
//   CLK          system clock; every state change happens on the rising edge
//   RESET        synchronous, active-high; clears all registers and VALID
//   WRITEDATA    value to store (ALU/shift result)
//   WRITEREG     destination register index
//   READREG1/2   source indices for read ports 1 and 2
//   WRITEENABLE  write request for this cycle
//   BUSYWAIT     memory stall; blocks the write while high
//   REGOUT1/2    contents of READREG1 / READREG2 (optionally forwarded)
//   VALID        bit i is set once register i has been written since reset
module reg_file_8x8 #(
  parameter int NREGS   = 8,
  parameter int WIDTH   = 8,
  parameter int FORWARD = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] WRITEDATA,
  input  logic [2:0]       WRITEREG,
  input  logic [2:0]       READREG1,
  input  logic [2:0]       READREG2,
  input  logic             WRITEENABLE,
  input  logic             BUSYWAIT,
  output logic [WIDTH-1:0] REGOUT1,
  output logic [WIDTH-1:0] REGOUT2,
  output logic [NREGS-1:0] VALID
);

  localparam bit FWD_EN = (FORWARD != 0);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] valid_q;

  // A write commits only when requested and memory is not stalling.
  logic wr_go;
  assign wr_go = WRITEENABLE && !BUSYWAIT;

  // Bypass is live only when the write really lands at the coming edge.
  // Reset beats the write, so a reset cycle must not forward.
  logic fwd_live;
  assign fwd_live = FWD_EN && wr_go && !RESET;

  // Storage. Reset has priority over any write in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      valid_q <= '0;
    end else if (wr_go) begin
      regs[WRITEREG]    <= WRITEDATA;
      valid_q[WRITEREG] <= 1'b1;
    end
  end

  // Read port 1.
  always_comb begin
    REGOUT1 = regs[READREG1];
    if (fwd_live && (READREG1 == WRITEREG)) begin
      REGOUT1 = WRITEDATA;
    end
  end

  // Read port 2.
  always_comb begin
    REGOUT2 = regs[READREG2];
    if (fwd_live && (READREG2 == WRITEREG)) begin
      REGOUT2 = WRITEDATA;
    end
  end

  assign VALID = valid_q;

endmodule
